// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, arbiter FSM states and the data type.
package alu_pkg;

  typedef logic [7:0] data_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_AND = 4'b1011;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping to 0.
module rr_grant #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment [ptr, N-1] has priority; the second pass covers the wrap.
    for (int j = 0; j < N; j++) begin
      if (!any && valid[j] && (IW'(j) >= ptr)) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end sharing one external combinational ALU among NUM_REQ requesters.
// Optional macro DIV_ZERO_CHK_EN adds rsp_err and forces 8'hFF on divide-by-zero.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_sel,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [3:0]           alu_sel,
  output data_t                alu_a,
  output data_t                alu_b,
  input  data_t                alu_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output data_t                rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef DIV_ZERO_CHK_EN
  ,
  output logic                 rsp_err
`endif
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [3:0]          sel_g;
  data_t               a_g, b_g;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_grant (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    sel_g = '0;
    a_g   = '0;
    b_g   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_g = req_sel[4*i +: 4];
        a_g   = req_a[8*i +: 8];
        b_g   = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Accept stage (IDLE), capture stage (EXEC), hold stage (RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef DIV_ZERO_CHK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_any) begin
            alu_sel <= sel_g;
            alu_a   <= a_g;
            alu_b   <= b_g;
            rsp_id  <= grant_idx;
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
          if ((alu_sel == OP_DIV) && (alu_b == '0)) begin
            rsp_data <= 8'hFF;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_y;
            rsp_err  <= 1'b0;
          end
`else
          rsp_data  <= alu_y;
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter (NUM_REQ=2) with a behavioural ALU model attached.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_sel;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [3:0]     alu_sel;
  logic [7:0]     alu_a, alu_b, alu_y;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [7:0]     rsp_data;
  logic [0:0]     rsp_id;
  logic           busy;
  logic           rsp_err_w;
`ifdef DIV_ZERO_CHK_EN
  logic           rsp_err;
  assign rsp_err_w = rsp_err;
`else
  assign rsp_err_w = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   stall_left = 0;
  cmd_t cq0[$];
  cmd_t cq1[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef DIV_ZERO_CHK_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  // Reference ALU sitting outside the arbiter, as in the real system.
  always_comb begin
    alu_y = 8'h00;
    case (alu_sel)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_MUL: alu_y = alu_a * alu_b;
      OP_DIV: alu_y = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      OP_SHL: alu_y = alu_a << alu_b[2:0];
      OP_SHR: alu_y = alu_a >> alu_b[2:0];
      OP_AND: alu_y = alu_a & alu_b;
      OP_OR:  alu_y = alu_a | alu_b;
      OP_EQ:  alu_y = {7'b0, alu_a == alu_b};
      default: alu_y = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rsp_ready = 1'b1;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        rsp_ready = 1'b1;
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else if (stall_left > 0) begin
        rsp_ready = 1'b0;
        stall_left--;
        chk("bp_data_hold", rsp_data, sb[0].data);
        chk("bp_id_hold", rsp_id, sb[0].id);
        chk("bp_req_ready_low", req_ready, 0);
      end else begin
        rsp_ready = 1'b1;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err_w, e.err);
      end
    end else begin
      rsp_ready = 1'b1;
    end
  end

  task automatic drive_heads();
    req_valid = '0;
    req_sel = '0;
    req_a = '0;
    req_b = '0;
    if (cq0.size() > 0) begin
      req_valid[0] = 1'b1;
      req_sel[3:0] = cq0[0].sel;
      req_a[7:0]   = cq0[0].a;
      req_b[7:0]   = cq0[0].b;
    end
    if (cq1.size() > 0) begin
      req_valid[1] = 1'b1;
      req_sel[7:4] = cq1[0].sel;
      req_a[15:8]  = cq1[0].a;
      req_b[15:8]  = cq1[0].b;
    end
  endtask

  task automatic run_queues(input int max_cycles);
    logic [N-1:0] acc;
    bit done;
    acc = '0;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      if (acc[0]) void'(cq0.pop_front());
      if (acc[1]) void'(cq1.pop_front());
      drive_heads();
      #1;
      acc = req_ready;
      chk("ready_onehot0", ($countones(acc) <= 1), 1);
      if (cq0.size() == 0 && cq1.size() == 0 && sb.size() == 0 && !busy && acc == '0)
        done = 1'b1;
    end
    if (!done) chk("run_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_sel = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_err", rsp_err_w, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADD from requester 0, latency checked cycle by cycle.
    req_valid = 2'b01;
    req_sel[3:0] = OP_ADD;
    req_a[7:0] = 8'd100;
    req_b[7:0] = 8'd27;
    sb.push_back('{id: 8'd0, data: 8'd127, err: 1'b0});
    #1 chk("single_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    chk("single_exec_no_rsp", rsp_valid, 0);
    chk("single_alu_a", alu_a, 8'd100);
    chk("single_busy", busy, 1);
    #1 chk("exec_ready_low", req_ready, 0);
    @(negedge clk);
    chk("single_rsp_latency", rsp_valid, 1);
    repeat (2) @(negedge clk);
    chk("single_idle", busy, 0);

    // Reset asserted while requester 1 is in EXEC: everything clears, no response.
    req_valid = 2'b10;
    req_sel[7:4] = OP_OR;
    req_a[15:8] = 8'd1;
    req_b[15:8] = 8'd2;
    #1 chk("abort_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    chk("abort_in_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_alu_sel", alu_sel, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_no_rsp", rsp_valid, 0);
    end

    // Contention: rr_ptr is back at 0, so grants go 0,1,0,1.
    cq0.push_back('{sel: OP_SUB, a: 8'd50, b: 8'd8});
    cq0.push_back('{sel: OP_SUB, a: 8'd50, b: 8'd8});
    cq1.push_back('{sel: OP_MUL, a: 8'd16, b: 8'd17});
    cq1.push_back('{sel: OP_MUL, a: 8'd16, b: 8'd17});
    sb.push_back('{id: 8'd0, data: 8'd42,  err: 1'b0});
    sb.push_back('{id: 8'd1, data: 8'h10,  err: 1'b0});
    sb.push_back('{id: 8'd0, data: 8'd42,  err: 1'b0});
    sb.push_back('{id: 8'd1, data: 8'h10,  err: 1'b0});
    run_queues(60);

    // Backpressure: five stalled cycles on the AND result, req1 waits.
    stall_left = 5;
    cq0.push_back('{sel: OP_AND, a: 8'hF0, b: 8'h3C});
    cq1.push_back('{sel: OP_OR,  a: 8'h01, b: 8'h02});
    sb.push_back('{id: 8'd0, data: 8'h30, err: 1'b0});
    sb.push_back('{id: 8'd1, data: 8'h03, err: 1'b0});
    run_queues(60);
    chk("bp_stall_consumed", stall_left, 0);

    // Undefined opcode yields 0; EQ of equal operands yields 1.
    cq0.push_back('{sel: 4'b0000, a: 8'd9, b: 8'd9});
    cq1.push_back('{sel: OP_EQ,   a: 8'd9, b: 8'd9});
    sb.push_back('{id: 8'd0, data: 8'd0, err: 1'b0});
    sb.push_back('{id: 8'd1, data: 8'd1, err: 1'b0});
    run_queues(40);

`ifdef DIV_ZERO_CHK_EN
    cq0.push_back('{sel: OP_DIV, a: 8'd200, b: 8'd0});
    cq1.push_back('{sel: OP_DIV, a: 8'd200, b: 8'd7});
    sb.push_back('{id: 8'd0, data: 8'hFF, err: 1'b1});
    sb.push_back('{id: 8'd1, data: 8'd28, err: 1'b0});
    run_queues(40);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
